// File: rtl/dac_spi_rx_if.sv
// Serial link and frame-report bundle between a DAC SPI master (or bench) and dac_spi_rx.
// The receiver uses the slave modport; whoever drives sync/sclk/sdi uses master.
interface dac_spi_rx_if #(
    parameter int DATA_WIDTH = 24,
    parameter int CODE_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
);
    logic                             sync_i;
    logic                             sclk_i;
    logic                             sdi_i;
    logic [CODE_WIDTH-1:0]            code_o;
    logic [DATA_WIDTH-CODE_WIDTH-1:0] cmd_o;
    logic                             valid_o;
    logic                             err_o;
    logic                             busy_o;
    logic [CNT_WIDTH-1:0]             frame_cnt_o;

    modport master (
        output sync_i, sclk_i, sdi_i,
        input  code_o, cmd_o, valid_o, err_o, busy_o, frame_cnt_o
    );

    modport slave (
        input  sync_i, sclk_i, sdi_i,
        output code_o, cmd_o, valid_o, err_o, busy_o, frame_cnt_o
    );
endinterface

// File: rtl/dac_spi_rx.sv
// SPI frame receiver for the DAC link: oversamples sync/sclk/sdi on clk_i, rebuilds
// MSB-first frames and reports code/cmd of good frames, or an error pulse for bad ones.
module dac_spi_rx #(
    parameter int DATA_WIDTH  = 24,
    parameter int CODE_WIDTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    dac_spi_rx_if.slave  bus
);
    localparam int CMD_WIDTH = DATA_WIDTH - CODE_WIDTH;
    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int FLUSH_W   = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_SHIFT,
        ST_CLOSE
    } state_t;

    // Synchronizer lanes per stage: {sync, sclk, sdi}
    logic [SYNC_STAGES-1:0][2:0] pipe_q, pipe_d;
    logic [1:0]                  edge_q, edge_d;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   ovf_q, ovf_d;
    logic [FLUSH_W-1:0]     flush_q, flush_d;
    logic [CODE_WIDTH-1:0]  code_q, code_d;
    logic [CMD_WIDTH-1:0]   cmd_q, cmd_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;

    logic sync_s, sclk_s, sdi_s;
    logic sync_fall, sync_rise, sclk_fall;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = {bus.sync_i, bus.sclk_i, bus.sdi_i};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign sync_s    = pipe_q[SYNC_STAGES-1][2];
    assign sclk_s    = pipe_q[SYNC_STAGES-1][1];
    assign sdi_s     = pipe_q[SYNC_STAGES-1][0];
    assign edge_d    = {sync_s, sclk_s};
    assign sync_fall = edge_q[1] & ~sync_s;
    assign sync_rise = ~edge_q[1] & sync_s;
    assign sclk_fall = edge_q[0] & ~sclk_s;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ovf_d       = ovf_q;
        flush_d     = flush_q;
        code_d      = code_q;
        cmd_d       = cmd_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            // The synchronizer is preset to idle after reset, so its stale ones must be
            // flushed out before trusting sync as high; otherwise a frame still in flight
            // at reset release would look like a fresh sync fall.
            ST_WAIT_IDLE: begin
                if (sync_s) begin
                    if (flush_q == FLUSH_W'(SYNC_STAGES)) begin
                        state_d = ST_IDLE;
                    end else begin
                        flush_d = flush_q + FLUSH_W'(1);
                    end
                end else begin
                    flush_d = '0;
                end
            end
            ST_IDLE: begin
                if (sync_fall) begin
                    bit_cnt_d = '0;
                    ovf_d     = 1'b0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sclk_fall && !sync_s) begin
                    if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        shift_d   = {shift_q[DATA_WIDTH-2:0], sdi_s};
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
                if (sync_rise) begin
                    state_d = ST_CLOSE;
                end
            end
            ST_CLOSE: begin
                if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH) && !ovf_q) begin
                    code_d      = shift_q[CODE_WIDTH-1:0];
                    cmd_d       = shift_q[DATA_WIDTH-1:CODE_WIDTH];
                    valid_d     = 1'b1;
                    frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                end else begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_q      <= '1;
            edge_q      <= '1;
            state_q     <= ST_WAIT_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            flush_q     <= '0;
            code_q      <= '0;
            cmd_q       <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            pipe_q      <= pipe_d;
            edge_q      <= edge_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            ovf_q       <= ovf_d;
            flush_q     <= flush_d;
            code_q      <= code_d;
            cmd_q       <= cmd_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.code_o      = code_q;
    assign bus.cmd_o       = cmd_q;
    assign bus.valid_o     = valid_q;
    assign bus.err_o       = err_q;
    assign bus.busy_o      = (state_q == ST_SHIFT);
    assign bus.frame_cnt_o = frame_cnt_q;
endmodule

// File: tb/tb_dac_spi_rx.sv
// Bench for dac_spi_rx: drives SPI frames and checks every cycle against a frame-level model
// (outcome decided by bit count, pulse due SYNC_STAGES+2 cycles after the sync pin rises).
module tb_dac_spi_rx;
    localparam int DW = 24;
    localparam int CW = 16;
    localparam int SS = 2;
    localparam int NW = 4;
    localparam int HALF = 3;

    typedef struct {
        int          cyc;
        bit          good;
        logic [15:0] code;
        logic [7:0]  cmd;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    bit   rst_edge;
    int   checks;
    int   errors;
    int   lat;

    exp_t        exp_q[$];
    logic [15:0] m_code;
    logic [7:0]  m_cmd;
    logic [3:0]  m_cnt;

    dac_spi_rx_if #(.DATA_WIDTH(DW), .CODE_WIDTH(CW), .CNT_WIDTH(NW)) bus ();

    dac_spi_rx #(
        .DATA_WIDTH (DW),
        .CODE_WIDTH (CW),
        .SYNC_STAGES(SS),
        .CNT_WIDTH  (NW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare process: DUT outputs versus the frame-level model on every cycle.
    always @(negedge clk) begin
        if (rst_edge) begin
            exp_q.delete();
            m_code = '0;
            m_cmd  = '0;
            m_cnt  = '0;
            chk("rst_valid", 32'(bus.valid_o), 0);
            chk("rst_err", 32'(bus.err_o), 0);
            chk("rst_busy", 32'(bus.busy_o), 0);
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missed_pulse", 32'(exp_q[0].cyc), 32'(cyc));
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                if (exp_q[0].good) begin
                    m_code = exp_q[0].code;
                    m_cmd  = exp_q[0].cmd;
                    m_cnt  = m_cnt + 4'd1;
                end
                chk("pulse_valid", 32'(bus.valid_o), 32'(exp_q[0].good));
                chk("pulse_err", 32'(bus.err_o), 32'(!exp_q[0].good));
                void'(exp_q.pop_front());
            end else begin
                chk("no_valid", 32'(bus.valid_o), 0);
                chk("no_err", 32'(bus.err_o), 0);
            end
        end
        chk("code", 32'(bus.code_o), 32'(m_code));
        chk("cmd", 32'(bus.cmd_o), 32'(m_cmd));
        chk("frame_cnt", 32'(bus.frame_cnt_o), 32'(m_cnt));
    end

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(6);
    endtask

    // Sends nbits bits MSB first (bit k = data[nbits-1-k]); sdi changes on sclk rise.
    // abort_at >= 0 pulses rst before that bit and expects no report for the frame.
    task automatic send_frame(input logic [31:0] data, input int nbits, input int abort_at,
                              output int latency);
        int c;
        bus.sync_i = 1'b0;
        tick(HALF);
        for (int k = 0; k < nbits; k++) begin
            if (k == abort_at) begin
                chk("busy_mid_frame", 32'(bus.busy_o), 1);
                rst = 1'b1;
                tick(3);
                chk("busy_in_reset", 32'(bus.busy_o), 0);
                rst = 1'b0;
            end
            bus.sclk_i = 1'b1;
            bus.sdi_i  = data[nbits-1-k];
            tick(HALF);
            bus.sclk_i = 1'b0;
            tick(HALF);
        end
        tick(2);
        bus.sync_i = 1'b1;
        c = cyc;
        if (abort_at < 0) begin
            exp_q.push_back('{c + SS + 2, (nbits == DW), data[15:0], data[23:16]});
        end
        latency = -1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if ((bus.valid_o || bus.err_o) && latency < 0) latency = k;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.sync_i = 1'b1;
        bus.sclk_i = 1'b0;
        bus.sdi_i  = 1'b0;
        tick(4);
        chk("reset_code", 32'(bus.code_o), 0);
        chk("reset_cnt", 32'(bus.frame_cnt_o), 0);
        rst = 1'b0;
        tick(6);

        // Single good frame, latency pinned.
        send_frame(32'h00_1234, 24, -1, lat);
        $display("frame 001234: latency %0d code %h cmd %h cnt %0d", lat, bus.code_o, bus.cmd_o, bus.frame_cnt_o);
        chk("t1_latency", 32'(lat), 4);
        chk("t1_code", 32'(bus.code_o), 32'h1234);
        chk("t1_cmd", 32'(bus.cmd_o), 32'h00);
        chk("t1_cnt", 32'(bus.frame_cnt_o), 1);

        // Back-to-back frames.
        do_reset();
        send_frame(32'h03_FFFF, 24, -1, lat);
        $display("frame 03FFFF: code %h cmd %h cnt %0d", bus.code_o, bus.cmd_o, bus.frame_cnt_o);
        chk("t2a_cmd", 32'(bus.cmd_o), 32'h03);
        tick(4);
        send_frame(32'h00_0000, 24, -1, lat);
        $display("frame 000000: code %h cmd %h cnt %0d", bus.code_o, bus.cmd_o, bus.frame_cnt_o);
        chk("t2_code", 32'(bus.code_o), 0);
        chk("t2_cmd", 32'(bus.cmd_o), 0);
        chk("t2_cnt", 32'(bus.frame_cnt_o), 2);

        // Short (23) and long (25) frames.
        send_frame(32'h091A2B, 23, -1, lat);
        $display("short frame: err latency %0d", lat);
        chk("t3_err_latency", 32'(lat), 4);
        send_frame({7'd0, 24'hAB_CDEF, 1'b1}, 25, -1, lat);
        $display("long frame: err latency %0d code %h cnt %0d", lat, bus.code_o, bus.frame_cnt_o);
        chk("t3_code", 32'(bus.code_o), 0);
        chk("t3_cnt", 32'(bus.frame_cnt_o), 2);

        // sclk toggles with sync high, then an empty frame.
        for (int k = 0; k < 10; k++) begin
            bus.sclk_i = 1'b1;
            bus.sdi_i  = ~bus.sdi_i;
            tick(HALF);
            bus.sclk_i = 1'b0;
            tick(HALF);
        end
        bus.sync_i = 1'b0;
        tick(8);
        bus.sync_i = 1'b1;
        exp_q.push_back('{cyc + SS + 2, 1'b0, 16'h0, 8'h0});
        tick(10);
        $display("empty frame: code %h cnt %0d", bus.code_o, bus.frame_cnt_o);
        chk("t4_cnt", 32'(bus.frame_cnt_o), 2);

        // Reset mid-frame, then a good frame.
        send_frame(32'h00_C3C3, 24, 12, lat);
        $display("aborted frame: latency %0d", lat);
        chk("t5_abort_silent", 32'(lat), 32'hFFFF_FFFF);
        send_frame(32'h00_5A5A, 24, -1, lat);
        $display("frame 005A5A: code %h cnt %0d", bus.code_o, bus.frame_cnt_o);
        chk("t5_code", 32'(bus.code_o), 32'h5A5A);
        chk("t5_cnt", 32'(bus.frame_cnt_o), 1);

        // Frame counter wrap (4-bit).
        do_reset();
        for (int k = 0; k < 15; k++) begin
            send_frame(32'h0100 + 32'(k), 24, -1, lat);
        end
        $display("after 15 frames: cnt %0d", bus.frame_cnt_o);
        chk("t6_cnt_full", 32'(bus.frame_cnt_o), 15);
        send_frame(32'h00_BEEF, 24, -1, lat);
        $display("wrap frame: code %h cnt %0d", bus.code_o, bus.frame_cnt_o);
        chk("t6_cnt_wrap", 32'(bus.frame_cnt_o), 0);
        chk("t6_code", 32'(bus.code_o), 32'hBEEF);

        tick(10);
        chk("pending_expectations", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
